axi_rd_sched: RTL
=================

# axi_rd_sched

Multi-port read request scheduler that sits in front of the AXI read master's user request interface. It arbitrates up to `NUM_PORTS` requesters round-robin and tags each request's AXI ID with the winning port index. It enforces a per-port outstanding-transaction limit and returns a per-port completion pulse when the matching last read beat is observed.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `PORT_OST_MAX`, 4: maximum outstanding reads per port, 1..15.
- `PORT_W`, `$clog2(NUM_PORTS)`: port index width; `AXI_ID_WIDTH` >= `PORT_W`.
- `CNT_W`, `$clog2(PORT_OST_MAX+1)`: outstanding counter width.

Ports:
- `clk` in 1: single clock; one clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `port_req_valid` in NUM_PORTS: per-port request valid.
- `port_req_ready` out NUM_PORTS: per-port accept; at most one bit set per cycle.
- `port_req_addr` in NUM_PORTS*`AXI_ADDR_WIDTH`: packed; port i at slice i.
- `port_req_len` in NUM_PORTS*`AXI_LEN_WIDTH`: burst length per port.
- `port_req_size` in NUM_PORTS*`AXI_SIZE_WIDTH`: beat size per port.
- `port_req_burst` in NUM_PORTS*`AXI_BURST_WIDTH`: burst type per port.
- `user_req_valid` out 1: request to the read master.
- `user_req_ready` in 1: read master accept.
- `user_req_id` out `AXI_ID_WIDTH`: {zeros, port index}.
- `user_req_addr`/`_len`/`_size`/`_burst` out: payload of the granted port.
- `mon_rvalid`, `mon_rready`, `mon_rlast` in 1: R channel monitor.
- `mon_rid` in `AXI_ID_WIDTH`: R channel ID monitor.
- `port_done` out NUM_PORTS: one-cycle pulse on completion of a port's burst.
- `port_ost_cnt` out NUM_PORTS*CNT_W: current outstanding count per port.
- `err_underflow` out 1: sticky flag; set when a completion arrives for a port whose count is 0.

## Operation
- Output stage: a single register slot, state EMPTY or FULL.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on `user_req_valid & user_req_ready` with no new grant.
  - FULL -> FULL on a handshake plus a new grant in the same cycle (back-to-back).
- Stage can accept when it is EMPTY or downstream handshakes this cycle.
- Port i is eligible when `port_req_valid[i]` is high and `cnt[i] < PORT_OST_MAX`.
- Arbitration: round-robin starting from `rr_ptr`; the first eligible port wins. Grant occurs only when the stage can accept.
- On a grant:
  - `port_req_ready[winner]` = 1.
  - Payload and ID are registered into the stage.
  - `rr_ptr` <= winner+1, wrapping to 0 after NUM_PORTS-1.
- `cnt[i]` increments on grant to i.
- `cnt[i]` decrements on `mon_rvalid & mon_rready & mon_rlast` with `mon_rid[PORT_W-1:0]==i`.
  - Both in the same cycle: count unchanged.
- Completion for a port with count 0: count stays 0, no `port_done` pulse, `err_underflow` set until reset.
- `mon_rid` bits above PORT_W are ignored. A port index >= NUM_PORTS is ignored with no error.
- The stage payload is stable while `user_req_valid & ~user_req_ready` (AXI valid-hold rule).

## Timing
- Reset values: `user_req_valid`=0, `user_req_id`/addr/len=0, `user_req_size`=`AXI_SIZE_1_BYTE`, `user_req_burst`=`AXI_BURST_INCR`, `port_done`=0, all counts 0, `err_underflow`=0, `rr_ptr`=0.
- `port_req_ready` is combinational from valid, counts, `rr_ptr`, stage state and `user_req_ready`. It is 0 during reset.
- Latency: a grant in cycle N gives `user_req_valid`=1 in N+1.
- Sustained throughput is one request per cycle when `user_req_ready` stays high.
- `port_done[i]` pulses in the cycle after the last-beat handshake. The count updates on the same edge.
- Eligibility uses the registered count, so the count reaches PORT_OST_MAX before a further grant is refused.
- Reset asserted mid-operation clears the stage; any held request is dropped and the requester must re-issue.

## Configuration
- `AXI_RD_SCHED_PRIO_EN`
  - Defined: port 0 has strict priority. If port 0 is eligible it wins, and `rr_ptr` is not updated. Other ports use round-robin among themselves.
  - Undefined: pure round-robin over all ports, as described above.

## Test plan
- Reset, then all 4 ports valid with `user_req_ready`=1 -> grants 0,1,2,3,0 on consecutive cycles; `user_req_id` = 0,1,2,3,0 one cycle later.
- Port 2 alone issues 5 requests with no completions, PORT_OST_MAX=4 -> 4 grants, then `port_req_ready[2]`=0 held. One rlast with rid=2 -> `port_done[2]` pulse, 5th grant next cycle.
- `user_req_ready`=0 for 3 cycles with the stage FULL (addr 0x1000) -> `user_req_valid`=1 and addr held at 0x1000, no new grants. Then ready=1 -> handshake, next grant the same cycle.
- Grant to port 1 and rlast with rid=1 in the same cycle, count=2 -> count stays 2; `port_done[1]` pulses.
- rlast with rid=3 while cnt[3]=0 -> `err_underflow`=1 and stays 1; no `port_done`. Reset -> `err_underflow` clears to 0.
- `AXI_RD_SCHED_PRIO_EN` defined, ports 0 and 1 continuously valid -> port 0 wins every cycle until `cnt[0]`=4, then port 1 is granted.

Source files
------------

// File: rtl/axi_rd_sched_if.sv
// Request-side bus of the read scheduler: per-port request inputs, granted request out to the
// read master, and the R channel monitor tap.
interface axi_rd_sched_if #(
  parameter int NUM_PORTS       = 4,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int AXI_SIZE_WIDTH  = 3,
  parameter int AXI_BURST_WIDTH = 2
);
  logic [NUM_PORTS-1:0]                 port_req_valid;
  logic [NUM_PORTS-1:0]                 port_req_ready;
  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0]  port_req_addr;
  logic [NUM_PORTS*AXI_LEN_WIDTH-1:0]   port_req_len;
  logic [NUM_PORTS*AXI_SIZE_WIDTH-1:0]  port_req_size;
  logic [NUM_PORTS*AXI_BURST_WIDTH-1:0] port_req_burst;

  logic                       user_req_valid;
  logic                       user_req_ready;
  logic [AXI_ID_WIDTH-1:0]    user_req_id;
  logic [AXI_ADDR_WIDTH-1:0]  user_req_addr;
  logic [AXI_LEN_WIDTH-1:0]   user_req_len;
  logic [AXI_SIZE_WIDTH-1:0]  user_req_size;
  logic [AXI_BURST_WIDTH-1:0] user_req_burst;

  logic                       mon_rvalid;
  logic                       mon_rready;
  logic                       mon_rlast;
  logic [AXI_ID_WIDTH-1:0]    mon_rid;

  modport slave (
    input  port_req_valid, port_req_addr, port_req_len, port_req_size, port_req_burst,
    output port_req_ready,
    output user_req_valid, user_req_id, user_req_addr, user_req_len, user_req_size, user_req_burst,
    input  user_req_ready,
    input  mon_rvalid, mon_rready, mon_rlast, mon_rid
  );

  modport master (
    output port_req_valid, port_req_addr, port_req_len, port_req_size, port_req_burst,
    input  port_req_ready,
    input  user_req_valid, user_req_id, user_req_addr, user_req_len, user_req_size, user_req_burst,
    output user_req_ready,
    output mon_rvalid, mon_rready, mon_rlast, mon_rid
  );
endinterface

// File: rtl/axi_rd_sched.sv
// Round-robin read request scheduler with per-port outstanding limits and completion pulses.
// Define AXI_RD_SCHED_PRIO_EN to give port 0 strict priority over the round-robin ports.
module axi_rd_sched #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_OST_MAX    = 4,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int AXI_SIZE_WIDTH  = 3,
  parameter int AXI_BURST_WIDTH = 2,
  parameter int PORT_W          = $clog2(NUM_PORTS),
  parameter int CNT_W           = $clog2(PORT_OST_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_rd_sched_if.slave              bus,
  output logic [NUM_PORTS-1:0]       port_done,
  output logic [NUM_PORTS*CNT_W-1:0] port_ost_cnt,
  output logic                       err_underflow
);
  localparam logic [AXI_SIZE_WIDTH-1:0]  AXI_SIZE_1_BYTE = '0;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR  = AXI_BURST_WIDTH'(1);
  localparam logic [CNT_W-1:0]           OST_MAX         = CNT_W'(PORT_OST_MAX);
  localparam logic [PORT_W:0]            NUM_P           = (PORT_W+1)'(NUM_PORTS);

  typedef enum logic {EMPTY, FULL} stage_t;
  stage_t state, state_nxt;

  logic [PORT_W-1:0]          rr_ptr;
  logic [CNT_W-1:0]           cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]       elig, gnt, cpl, dec;
  logic                       can_accept, grant, found, upd_ptr, r_last;
  logic [PORT_W-1:0]          win;
  logic [PORT_W:0]            idx;

  logic [AXI_ADDR_WIDTH-1:0]  sel_addr, addr_q;
  logic [AXI_LEN_WIDTH-1:0]   sel_len, len_q;
  logic [AXI_SIZE_WIDTH-1:0]  sel_size, size_q;
  logic [AXI_BURST_WIDTH-1:0] sel_burst, burst_q;
  logic [AXI_ID_WIDTH-1:0]    id_q;
  logic                       unused_rid;

  assign unused_rid = ^bus.mon_rid;
  assign r_last     = bus.mon_rvalid & bus.mon_rready & bus.mon_rlast;
  assign can_accept = (state == EMPTY) || bus.user_req_ready;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = bus.port_req_valid[i] && (cnt[i] < OST_MAX);
      cpl[i]  = r_last && (bus.mon_rid[PORT_W-1:0] == PORT_W'(i));
      dec[i]  = cpl[i] && (cnt[i] != '0);
    end
  end

  // Search starts at rr_ptr; a port-0 priority win leaves the pointer alone.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    upd_ptr = 1'b0;
    idx     = '0;
`ifdef AXI_RD_SCHED_PRIO_EN
    if (elig[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, rr_ptr} + (PORT_W+1)'(k);
      if (idx >= NUM_P) idx = idx - NUM_P;
      if (!found && elig[idx[PORT_W-1:0]]) begin
        win     = idx[PORT_W-1:0];
        found   = 1'b1;
        upd_ptr = 1'b1;
      end
    end
  end

  assign grant = found && can_accept && !rst;

  always_comb begin
    gnt       = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[i] = grant && (win == PORT_W'(i));
      if (win == PORT_W'(i)) begin
        sel_addr  = bus.port_req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_len   = bus.port_req_len[i*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
        sel_size  = bus.port_req_size[i*AXI_SIZE_WIDTH +: AXI_SIZE_WIDTH];
        sel_burst = bus.port_req_burst[i*AXI_BURST_WIDTH +: AXI_BURST_WIDTH];
      end
    end
  end

  assign bus.port_req_ready = gnt;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL:  if (bus.user_req_ready && !grant) state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      rr_ptr  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= AXI_SIZE_1_BYTE;
      burst_q <= AXI_BURST_INCR;
    end else begin
      state <= state_nxt;
      // Payload only loads on a grant, so it holds while valid waits for ready.
      if (grant) begin
        id_q    <= AXI_ID_WIDTH'(win);
        addr_q  <= sel_addr;
        len_q   <= sel_len;
        size_q  <= sel_size;
        burst_q <= sel_burst;
        if (upd_ptr) begin
          rr_ptr <= (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + PORT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
      port_done     <= '0;
      err_underflow <= 1'b0;
    end else begin
      port_done <= dec;
      if ((cpl & ~dec) != '0) err_underflow <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[i] && !dec[i]) cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!gnt[i] && dec[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) port_ost_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign bus.user_req_valid = (state == FULL);
  assign bus.user_req_id    = id_q;
  assign bus.user_req_addr  = addr_q;
  assign bus.user_req_len   = len_q;
  assign bus.user_req_size  = size_q;
  assign bus.user_req_burst = burst_q;
endmodule
